// File: rtl/cpu_multicycle_pkg.sv
// Shared encodings for cpu_multicycle: opcodes, funct fields, FSM states and ALU operations.
// The MUL state only exists when CPU_MULTICYCLE_MUL_EN is defined.
package cpu_multicycle_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // srai carries 010000 in ir[31:26]; ir[25] is the top shamt bit at XLEN = 64
  localparam logic [5:0] F6_SRAI = 6'b010000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_WB     = 3'd2,
    S_HALT   = 3'd3
`ifdef CPU_MULTICYCLE_MUL_EN
    ,
    S_MUL    = 3'd4
`endif
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SRA,
    ALU_MUL
  } alu_op_e;

endpackage

// File: rtl/cpu_multicycle_if.sv
// Instruction-fetch handshake, retire trace and status of cpu_multicycle.
// imem: the core holds imem_req_o and a stable imem_addr_o until a cycle with imem_ready_i = 1, when imem_rdata_i is taken.
interface cpu_multicycle_if #(
  parameter int XLEN = 32
);
  import cpu_multicycle_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic [31:0]     imem_rdata_i;
  logic            retire_valid_o;
  logic [XLEN-1:0] retire_pc_o;
  logic [4:0]      retire_rd_o;
  logic [XLEN-1:0] retire_data_o;
  logic            halted_o;
  state_e          state;

  modport master (
    output imem_req_o, imem_addr_o, retire_valid_o, retire_pc_o, retire_rd_o,
           retire_data_o, halted_o, state,
    input  imem_ready_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, retire_valid_o, retire_pc_o, retire_rd_o,
           retire_data_o, halted_o, state,
    output imem_ready_i, imem_rdata_i
  );

endinterface

// File: rtl/cpu_regfile.sv
// NUM_REGS x XLEN register file: two asynchronous read ports, one synchronous write port.
// x0 is never written and always reads as zero.
module cpu_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
  output logic [XLEN-1:0]             rdata_a,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
  output logic [XLEN-1:0]             rdata_b,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [XLEN-1:0]             wdata
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32 integer-subset core: FETCH -> DECODE -> WB, illegal instructions park it in HALT.
// Define CPU_MULTICYCLE_MUL_EN to make mul legal, executed by an XLEN-cycle shift-add MUL state.
module cpu_multicycle
  import cpu_multicycle_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic              clk_i,
  input logic              rst_i,
  cpu_multicycle_if.master bus
);

  localparam int SHW = $clog2(XLEN);
  localparam int AW  = $clog2(NUM_REGS);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] result_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_sext, op_a, op_b, alu_result;
  logic [SHW-1:0]  shamt;
  alu_op_e         alu_op;
  logic            legal, use_imm, uses_rs2, wb_en;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm_sext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

  cpu_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk_i),
    .rst     (rst_i),
    .raddr_a (rs1[AW-1:0]),
    .rdata_a (rs1_val),
    .raddr_b (rs2[AW-1:0]),
    .rdata_b (rs2_val),
    .we      (wb_en),
    .waddr   (rd[AW-1:0]),
    .wdata   (result_q)
  );

  // Register indices are range-checked here, so the regfile only ever sees in-range addresses.
  always_comb begin
    alu_op   = ALU_ADD;
    legal    = 1'b0;
    use_imm  = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs2 = 1'b1;
        legal    = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:     alu_op = ALU_SLL;
          {F7_BASE, F3_XOR}:     alu_op = ALU_XOR;
          {F7_BASE, F3_OR}:      alu_op = ALU_OR;
          {F7_BASE, F3_AND}:     alu_op = ALU_AND;
`ifdef CPU_MULTICYCLE_MUL_EN
          {F7_MULDIV, F3_ADD_SUB}: alu_op = ALU_MUL;
`endif
          default:               legal  = 1'b0;
        endcase
      end
      OP_I: begin
        use_imm = 1'b1;
        case (funct3)
          F3_ADD_SUB: legal = 1'b1;
          F3_SR: begin
            alu_op = ALU_SRA;
            legal  = (ir_q[31:26] == F6_SRAI) && ((ir_q[25:20] >> SHW) == 6'd0);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (({1'b0, rd} >= 6'(NUM_REGS)) || ({1'b0, rs1} >= 6'(NUM_REGS)) ||
        (uses_rs2 && ({1'b0, rs2} >= 6'(NUM_REGS)))) begin
      legal = 1'b0;
    end
  end

  assign op_a  = rs1_val;
  assign op_b  = use_imm ? imm_sext : rs2_val;
  assign shamt = op_b[SHW-1:0];

  // mul starts from a zero accumulator; the MUL state builds the product in result_q
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_SLL: alu_result = op_a << shamt;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_SRA: alu_result = $signed(op_a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

`ifdef CPU_MULTICYCLE_MUL_EN
  logic [XLEN-1:0] mcand_q, mplier_q;
  logic [SHW-1:0]  mul_cnt_q;
  logic            mul_last;

  assign mul_last = (mul_cnt_q == SHW'(XLEN - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      mul_cnt_q <= '0;
    end else if (state_q == S_DECODE) begin
      mcand_q   <= op_a;
      mplier_q  <= op_b;
      mul_cnt_q <= '0;
    end else if (state_q == S_MUL) begin
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_q >> 1;
      mul_cnt_q <= mul_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.imem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) state_d = S_HALT;
`ifdef CPU_MULTICYCLE_MUL_EN
        else if (alu_op == ALU_MUL) state_d = S_MUL;
`endif
        else state_d = S_WB;
      end
`ifdef CPU_MULTICYCLE_MUL_EN
      S_MUL:    if (mul_last) state_d = S_WB;
`endif
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      result_q <= '0;
    end else begin
      if ((state_q == S_FETCH) && bus.imem_ready_i) ir_q <= bus.imem_rdata_i;
      if (state_q == S_DECODE) result_q <= alu_result;
`ifdef CPU_MULTICYCLE_MUL_EN
      if ((state_q == S_MUL) && mplier_q[0]) result_q <= result_q + mcand_q;
`endif
      if (state_q == S_WB) pc_q <= pc_q + XLEN'(4);
    end
  end

  assign wb_en = (state_q == S_WB) && (rd != 5'd0);

  // Request is masked while reset is held so it first rises on the cycle after release.
  assign bus.imem_req_o     = (state_q == S_FETCH) && !rst_i;
  assign bus.imem_addr_o    = pc_q;
  assign bus.retire_valid_o = (state_q == S_WB);
  assign bus.retire_pc_o    = (state_q == S_WB) ? pc_q : '0;
  assign bus.retire_rd_o    = (state_q == S_WB) ? rd : 5'd0;
  assign bus.retire_data_o  = (state_q == S_WB) ? result_q : '0;
  assign bus.halted_o       = (state_q == S_HALT);
  assign bus.state          = state_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: directed and random straight-line programs checked against an
// instruction-level reference model, plus a NUM_REGS = 16 instance for register-range decoding.
module tb_cpu_multicycle;
  import cpu_multicycle_pkg::*;

  localparam int XLEN   = 32;
  localparam int BUDGET = 3000;
  localparam int K_ADD = 0, K_SUB = 1, K_SLL = 2, K_XOR = 3, K_OR = 4, K_AND = 5;
  localparam int K_ADDI = 6, K_SRAI = 7, K_MUL = 8, K_SRAI_BAD = 9, K_BADOP = 10;

  typedef struct {
    int kind;
    int rd;
    int rs1;
    int rs2;
    int imm;
  } ins_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [7:0]  lat;
  } ret_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst16 = 1'b1;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  ins_t prog[$];
  ret_t exp_q[$];
  int   exp_n;
  logic [31:0] mem   [64];
  logic [31:0] mem16 [64];

  cpu_multicycle_if #(.XLEN(XLEN)) bus ();
  cpu_multicycle_if #(.XLEN(XLEN)) bus16 ();

  cpu_multicycle #(.XLEN(XLEN), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  cpu_multicycle #(.XLEN(XLEN), .NUM_REGS(16), .RESET_PC(32'h0)) dut16 (
    .clk_i (clk),
    .rst_i (rst16),
    .bus   (bus16.master)
  );

  assign bus.imem_rdata_i   = mem[bus.imem_addr_o[7:2]];
  assign bus16.imem_rdata_i = mem16[bus16.imem_addr_o[7:2]];
  assign bus16.imem_ready_i = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input ins_t x);
    logic [4:0]  d, s1, s2;
    logic [11:0] imm;
    d   = x.rd[4:0];
    s1  = x.rs1[4:0];
    s2  = x.rs2[4:0];
    imm = x.imm[11:0];
    case (x.kind)
      K_ADD:      enc = {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      K_SUB:      enc = {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
      K_SLL:      enc = {7'b0000000, s2, s1, 3'b001, d, 7'b0110011};
      K_XOR:      enc = {7'b0000000, s2, s1, 3'b100, d, 7'b0110011};
      K_OR:       enc = {7'b0000000, s2, s1, 3'b110, d, 7'b0110011};
      K_AND:      enc = {7'b0000000, s2, s1, 3'b111, d, 7'b0110011};
      K_MUL:      enc = {7'b0000001, s2, s1, 3'b000, d, 7'b0110011};
      K_ADDI:     enc = {imm, s1, 3'b000, d, 7'b0010011};
      K_SRAI:     enc = {7'b0100000, imm[4:0], s1, 3'b101, d, 7'b0010011};
      K_SRAI_BAD: enc = {7'b0100001, imm[4:0], s1, 3'b101, d, 7'b0010011};
      default:    enc = 32'h0000007f;
    endcase
  endfunction

  task automatic add_ins(input int kind, input int rd, input int rs1, input int rs2, input int imm);
    ins_t x;
    x.kind = kind; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.imm = imm;
    prog.push_back(x);
  endtask

  // Reference model: executes the program instruction by instruction on an array of registers.
  task automatic build_model();
    logic [31:0] m [32];
    logic [31:0] a, b, immv, res, pc;
    ret_t r;
    bit mul_ok;
`ifdef CPU_MULTICYCLE_MUL_EN
    mul_ok = 1'b1;
`else
    mul_ok = 1'b0;
`endif
    foreach (m[i]) m[i] = 32'h0;
    pc = 32'h0;
    exp_q.delete();
    exp_n = 0;
    for (int i = 0; i < prog.size(); i++) begin
      if (prog[i].kind == K_SRAI_BAD || prog[i].kind == K_BADOP) break;
      if (prog[i].kind == K_MUL && !mul_ok) break;
      a    = m[prog[i].rs1];
      b    = m[prog[i].rs2];
      immv = prog[i].imm;
      case (prog[i].kind)
        K_ADD:   res = a + b;
        K_SUB:   res = a - b;
        K_SLL:   res = a << b[4:0];
        K_XOR:   res = a ^ b;
        K_OR:    res = a | b;
        K_AND:   res = a & b;
        K_MUL:   res = a * b;
        K_ADDI:  res = a + immv;
        default: res = 32'($signed(a) >>> immv[4:0]);
      endcase
      if (prog[i].rd != 0) m[prog[i].rd] = res;
      r.pc   = pc;
      r.rd   = 5'(prog[i].rd);
      r.data = res;
      r.lat  = (prog[i].kind == K_MUL) ? 8'(XLEN + 2) : 8'd2;
      exp_q.push_back(r);
      exp_n++;
      pc = pc + 32'd4;
    end
  endtask

  task automatic gen_random(input int n);
    int r, k;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 11));
      k = (r <= 5) ? r : ((r <= 9) ? K_ADDI : K_SRAI);
      add_ins(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              (k == K_SRAI) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048);
    end
    if ($urandom_range(0, 2) == 0) add_ins(K_SRAI_BAD, 1, 2, 0, 3);
  endtask

  // Runs prog from reset; ready is held low for `stall` cycles, then high with probability ready_pct.
  task automatic run_prog(input string name, input int ready_pct, input int stall,
                          input int abort_cyc, input bit cpi_check);
    int cyc, fetch_cyc, n_ret, halt_cyc;
    bit halted_seen, waiting, done;
    logic [31:0] wait_addr;
    ret_t e;
    foreach (mem[i]) mem[i] = 32'h0000007f;
    for (int i = 0; i < prog.size(); i++) mem[i] = enc(prog[i]);
    build_model();
    rst = 1'b1;
    bus.imem_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({name, ".rst_req"},    64'(bus.imem_req_o),     64'd0);
    check({name, ".rst_valid"},  64'(bus.retire_valid_o), 64'd0);
    check({name, ".rst_halted"}, 64'(bus.halted_o),       64'd0);
    check({name, ".rst_pc"},     64'(bus.imem_addr_o),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; fetch_cyc = 0; n_ret = 0; halt_cyc = 0;
    halted_seen = 1'b0; waiting = 1'b0; done = 1'b0; wait_addr = '0;
    while (!done && cyc < BUDGET) begin
      cyc++;
      if (cyc > 1) @(negedge clk);
      #1;
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        #1;
        check({name, ".abort_req"},    64'(bus.imem_req_o),     64'd0);
        check({name, ".abort_valid"},  64'(bus.retire_valid_o), 64'd0);
        check({name, ".abort_halted"}, 64'(bus.halted_o),       64'd0);
        check({name, ".abort_pc"},     64'(bus.imem_addr_o),    64'd0);
        @(negedge clk);
        #1;
        check({name, ".abort_no_retire"}, 64'(bus.retire_valid_o), 64'd0);
        exp_q.delete();
        prog.delete();
        return;
      end
      bus.imem_ready_i = (cyc > stall) && (int'($urandom_range(0, 99)) < ready_pct);
      if (waiting) begin
        check({name, ".wait_req_held"},  64'(bus.imem_req_o),  64'd1);
        check({name, ".wait_addr_held"}, 64'(bus.imem_addr_o), 64'(wait_addr));
      end
      if (bus.imem_req_o) begin
        check({name, ".fetch_addr"}, 64'(bus.imem_addr_o), 64'(4 * n_ret));
        if (bus.imem_ready_i) fetch_cyc = cyc;
        waiting   = !bus.imem_ready_i;
        wait_addr = bus.imem_addr_o;
      end else begin
        waiting = 1'b0;
      end
      if (bus.retire_valid_o) begin
        if (exp_q.size() == 0) begin
          check({name, ".extra_retire"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check({name, ".retire_pc"}, 64'(bus.retire_pc_o), 64'(e.pc));
          check({name, ".retire_rd"}, 64'(bus.retire_rd_o), 64'(e.rd));
          if (e.rd != 5'd0) check({name, ".retire_data"}, 64'(bus.retire_data_o), 64'(e.data));
          check({name, ".retire_latency"}, 64'(cyc - fetch_cyc), 64'(e.lat));
          if (cpi_check) check({name, ".retire_cycle"}, 64'(cyc), 64'(3 * (n_ret + 1)));
          n_ret++;
        end
      end
      if (bus.halted_o && !halted_seen) begin
        halted_seen = 1'b1;
        halt_cyc    = cyc;
        check({name, ".halt_latency"}, 64'(cyc - fetch_cyc), 64'd2);
      end
      if (halted_seen) begin
        check({name, ".halt_quiet"}, 64'({bus.imem_req_o, bus.retire_valid_o, bus.halted_o}), 64'd1);
        if (cyc >= halt_cyc + 4) done = 1'b1;
      end
    end
    check({name, ".retire_count"}, 64'(n_ret), 64'(exp_n));
    check({name, ".halted"}, 64'(halted_seen), 64'd1);
    prog.delete();
  endtask

  // RV32E instance: addi x15 retires, then an out-of-range register index halts it.
  task automatic run_rv32e(input int variant);
    ins_t x;
    int n_ret;
    bit hseen;
    foreach (mem16[i]) mem16[i] = 32'h0000007f;
    x.kind = K_ADDI; x.rd = 15; x.rs1 = 0; x.rs2 = 0; x.imm = 9;
    mem16[0] = enc(x);
    if (variant == 0) begin
      x.kind = K_ADDI; x.rd = 20; x.rs1 = 0; x.imm = 1;
    end else begin
      x.kind = K_ADD; x.rd = 3; x.rs1 = 17; x.rs2 = 0; x.imm = 0;
    end
    mem16[1] = enc(x);
    rst16 = 1'b1;
    repeat (2) @(negedge clk);
    rst16 = 1'b0;
    n_ret = 0;
    hseen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (bus16.retire_valid_o) begin
        check("rv32e.retire_rd",    64'(bus16.retire_rd_o),   64'd15);
        check("rv32e.retire_data",  64'(bus16.retire_data_o), 64'd9);
        check("rv32e.retire_cycle", 64'(c),                   64'd3);
        n_ret++;
      end
      if (bus16.halted_o && !hseen) begin
        hseen = 1'b1;
        check("rv32e.halt_cycle", 64'(c), 64'd6);
      end
    end
    check("rv32e.retire_count", 64'(n_ret), 64'd1);
    check("rv32e.halted",       64'(hseen), 64'd1);
    check("rv32e.halt_req",     64'(bus16.imem_req_o), 64'd0);
  endtask

  initial begin
    bus.imem_ready_i = 1'b0;

    add_ins(K_ADDI, 1, 0, 0, 5); add_ins(K_ADDI, 2, 0, 0, -3); add_ins(K_ADD, 3, 1, 2, 0);
    run_prog("basic", 100, 0, 0, 1'b1);

    add_ins(K_ADDI, 1, 0, 0, 5); add_ins(K_ADDI, 2, 0, 0, -3); add_ins(K_ADD, 3, 1, 2, 0);
    run_prog("stall", 100, 4, 0, 1'b0);

    add_ins(K_ADDI, 4, 0, 0, -16); add_ins(K_SRAI, 5, 4, 0, 2);
    add_ins(K_ADDI, 6, 0, 0, 33);  add_ins(K_ADDI, 7, 0, 0, 3);  add_ins(K_SLL, 8, 7, 6, 0);
    add_ins(K_ADDI, 0, 0, 0, 7);   add_ins(K_ADD, 9, 0, 0, 0);   add_ins(K_OR, 10, 5, 8, 0);
    add_ins(K_BADOP, 0, 0, 0, 0);  add_ins(K_ADDI, 11, 0, 0, 1);
    run_prog("shifts_x0", 100, 0, 0, 1'b1);

    add_ins(K_ADDI, 1, 0, 0, -1); add_ins(K_SRAI_BAD, 2, 1, 0, 2); add_ins(K_ADDI, 3, 0, 0, 4);
    run_prog("srai_shamt", 100, 0, 0, 1'b0);

    add_ins(K_ADDI, 1, 0, 0, 7); add_ins(K_ADDI, 2, 0, 0, -3);
    add_ins(K_MUL, 3, 1, 2, 0);  add_ins(K_ADD, 4, 3, 0, 0);
    run_prog("mul", 100, 0, 0, 1'b0);

    add_ins(K_ADDI, 1, 0, 0, 7); add_ins(K_ADDI, 2, 0, 0, -3);
    add_ins(K_MUL, 3, 1, 2, 0);  add_ins(K_ADD, 4, 3, 0, 0);
    run_prog("mul_abort", 100, 0, 10, 1'b0);

    add_ins(K_ADD, 5, 1, 2, 0); add_ins(K_ADDI, 6, 3, 0, 1); add_ins(K_OR, 7, 4, 6, 0);
    run_prog("after_reset", 70, 0, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      gen_random(int'($urandom_range(15, 40)));
      run_prog("random", int'($urandom_range(40, 100)), int'($urandom_range(0, 3)), 0, 1'b0);
    end

    run_rv32e(0);
    run_rv32e(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
